// File: rtl/echo_decoder_if.sv
// echo_decoder_if: frame control, receive echo and per-frame result bundle for echo_decoder.
interface echo_decoder_if;
    logic        enable;
    logic        frame_sync;
    logic        echo;
    logic [15:0] pattern;
    logic [15:0] mask;
    logic [15:0] pulse_len;
    logic [31:0] blank_len;
    logic [31:0] listen_len;
    logic [4:0]  max_err;
    logic        busy;
    logic        result_valid;
    logic [31:0] tof;
    logic [15:0] rx_bits;
    logic [4:0]  err_cnt;
    logic        hit;
    logic        timeout;

    modport master (
        output enable, frame_sync, echo, pattern, mask, pulse_len, blank_len, listen_len, max_err,
        input  busy, result_valid, tof, rx_bits, err_cnt, hit, timeout
    );

    modport slave (
        input  enable, frame_sync, echo, pattern, mask, pulse_len, blank_len, listen_len, max_err,
        output busy, result_valid, tof, rx_bits, err_cnt, hit, timeout
    );
endinterface

// File: rtl/echo_decoder.sv
// echo_decoder: time-of-flight measurement and phase-code demodulation of an ultrasound echo.
// Optional macro ECHO_SYNC_EN puts a 2-FF synchronizer in front of the echo input.
module echo_decoder #(
    parameter int unsigned HALF_PERIOD = 9
) (
    input  logic          clk,
    input  logic          rstn,
    echo_decoder_if.slave bus
);
    localparam int unsigned CNT_W = 32;
    localparam int unsigned SYM_W = 4;
    localparam int unsigned ERR_W = 5;
    localparam logic [CNT_W-1:0] TWO_HP   = CNT_W'(2 * HALF_PERIOD);
    localparam logic [CNT_W-1:0] HP_LAST  = CNT_W'(HALF_PERIOD - 1);
    localparam logic             REF_INIT = (HALF_PERIOD > 1) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] PH_INIT  = (HALF_PERIOD > 1) ? CNT_W'(1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_LISTEN, S_DECODE, S_REPORT} state_t;

    state_t            r_state, w_state_next;
    logic              w_echo, r_echo_prev;
    logic [15:0]       r_pattern, r_mask, r_rx_acc, w_rx_final;
    logic [CNT_W-1:0]  r_sym_len, r_blank, r_listen, r_tof_cnt, r_tof_meas;
    logic [CNT_W-1:0]  r_agree, r_win_cnt, r_ph_cnt, w_agree_sum, w_sym_len_in;
    logic [ERR_W-1:0]  r_max_err, r_err_acc, w_err_sum;
    logic [SYM_W-1:0]  r_sym, r_k0, w_k0;
    logic [15:0]       w_pl_eff;
    logic              r_ref, r_ref_bit;
    logic              w_start, w_arrival, w_listen_to, w_win_end, w_last_win;
    logic              w_rel_bit, w_abs_bit, w_sym_err;
    logic              w_go_decode, w_done_decode, w_done_timeout;
    logic              r_busy, r_valid, r_hit, r_timeout;
    logic [CNT_W-1:0]  r_tof;
    logic [15:0]       r_rx_bits;
    logic [ERR_W-1:0]  r_err_cnt;

`ifdef ECHO_SYNC_EN
    logic [1:0] r_echo_sync;
    // Two-stage synchronizer for the asynchronous comparator output
    always_ff @(posedge clk) begin
        if (!rstn) r_echo_sync <= '0;
        else       r_echo_sync <= {r_echo_sync[0], bus.echo};
    end
    assign w_echo = r_echo_sync[1];
`else
    assign w_echo = bus.echo;
`endif

    // First masked-in symbol index (k0) from the incoming mask
    always_comb begin
        w_k0 = '0;
        for (int i = 15; i >= 0; i--) begin
            if (bus.mask[i]) w_k0 = SYM_W'(i);
        end
    end

    assign w_pl_eff     = (bus.pulse_len == '0) ? 16'd1 : bus.pulse_len;
    assign w_sym_len_in = CNT_W'(w_pl_eff) * TWO_HP;

    assign w_start     = bus.enable && bus.frame_sync && (r_state != S_REPORT);
    assign w_arrival   = (r_state == S_LISTEN) && w_echo && !r_echo_prev && (r_tof_cnt >= r_blank);
    assign w_listen_to = (r_state == S_LISTEN) && !w_arrival && (r_tof_cnt == r_listen);
    assign w_agree_sum = r_agree + CNT_W'(w_echo == r_ref);
    assign w_win_end   = (r_state == S_DECODE) && (r_win_cnt == r_sym_len - CNT_W'(1));
    assign w_last_win  = w_win_end && (r_sym == SYM_W'(15));
    // Majority vote against the local reference; a tie decodes as 0
    assign w_rel_bit   = {w_agree_sum, 1'b0} < {1'b0, r_sym_len};
    assign w_abs_bit   = w_rel_bit ^ r_ref_bit;
    assign w_sym_err   = r_mask[r_sym] && (w_abs_bit != r_pattern[r_sym]);
    assign w_err_sum   = r_err_acc + ERR_W'(w_sym_err);

    // Final received word including the decision of window 15
    always_comb begin
        w_rx_final = r_rx_acc;
        if (r_mask[15]) w_rx_final[15] = w_abs_bit;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic and frame-completion strobes
    always_comb begin
        w_state_next   = r_state;
        w_go_decode    = 1'b0;
        w_done_decode  = 1'b0;
        w_done_timeout = 1'b0;
        if (!bus.enable) begin
            w_state_next = S_IDLE;
        end else if (w_start) begin
            if (bus.mask == '0) begin
                w_state_next   = S_REPORT;
                w_done_timeout = 1'b1;
            end else begin
                w_state_next = S_LISTEN;
            end
        end else begin
            case (r_state)
                S_IDLE:   w_state_next = S_IDLE;
                S_LISTEN: begin
                    if (w_arrival) begin
                        w_state_next = S_DECODE;
                        w_go_decode  = 1'b1;
                    end else if (w_listen_to) begin
                        w_state_next   = S_REPORT;
                        w_done_timeout = 1'b1;
                    end
                end
                S_DECODE: begin
                    if (w_last_win) begin
                        w_state_next  = S_REPORT;
                        w_done_decode = 1'b1;
                    end
                end
                S_REPORT: w_state_next = S_IDLE;
                default:  w_state_next = S_IDLE;
            endcase
        end
    end

    // Config latch, tof counter, symbol correlator and registered result outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_echo_prev <= 1'b0;
            r_pattern   <= '0;
            r_mask      <= '0;
            r_sym_len   <= '0;
            r_blank     <= '0;
            r_listen    <= '0;
            r_max_err   <= '0;
            r_k0        <= '0;
            r_ref_bit   <= 1'b0;
            r_tof_cnt   <= '0;
            r_tof_meas  <= '0;
            r_agree     <= '0;
            r_win_cnt   <= '0;
            r_ph_cnt    <= '0;
            r_ref       <= 1'b0;
            r_sym       <= '0;
            r_rx_acc    <= '0;
            r_err_acc   <= '0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_tof       <= '0;
            r_rx_bits   <= '0;
            r_err_cnt   <= '0;
            r_hit       <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_echo_prev <= w_echo;
            // Count holds clocks elapsed since frame_sync in the current cycle
            if (w_start) begin
                r_pattern <= bus.pattern;
                r_mask    <= bus.mask;
                r_sym_len <= w_sym_len_in;
                r_blank   <= bus.blank_len;
                r_listen  <= bus.listen_len;
                r_max_err <= bus.max_err;
                r_k0      <= w_k0;
                r_ref_bit <= bus.pattern[w_k0];
                r_tof_cnt <= CNT_W'(1);
            end else if ((r_state == S_LISTEN) && (r_tof_cnt != '1)) begin
                r_tof_cnt <= r_tof_cnt + CNT_W'(1);
            end

            if (w_go_decode) begin
                // Arrival cycle is sample 0 of the first window; echo and ref are both high
                r_tof_meas <= r_tof_cnt;
                r_agree    <= CNT_W'(1);
                r_win_cnt  <= CNT_W'(1);
                r_ref      <= REF_INIT;
                r_ph_cnt   <= PH_INIT;
                r_sym      <= r_k0;
                r_rx_acc   <= '0;
                r_err_acc  <= '0;
            end else if (r_state == S_DECODE) begin
                if (r_ph_cnt == HP_LAST) begin
                    r_ph_cnt <= '0;
                    r_ref    <= ~r_ref;
                end else begin
                    r_ph_cnt <= r_ph_cnt + CNT_W'(1);
                end
                if (w_win_end) begin
                    r_agree   <= '0;
                    r_win_cnt <= '0;
                    r_sym     <= r_sym + SYM_W'(1);
                    r_err_acc <= w_err_sum;
                    if (r_mask[r_sym]) r_rx_acc[r_sym] <= w_abs_bit;
                end else begin
                    r_agree   <= w_agree_sum;
                    r_win_cnt <= r_win_cnt + CNT_W'(1);
                end
            end

            r_busy  <= (w_state_next != S_IDLE);
            r_valid <= w_done_decode || w_done_timeout;
            if (w_done_timeout) begin
                r_timeout <= 1'b1;
                r_rx_bits <= '0;
                r_err_cnt <= '0;
                r_hit     <= 1'b0;
            end else if (w_done_decode) begin
                r_timeout <= 1'b0;
                r_tof     <= r_tof_meas;
                r_rx_bits <= w_rx_final;
                r_err_cnt <= w_err_sum;
                r_hit     <= (w_err_sum <= r_max_err);
            end
        end
    end

    assign bus.busy         = r_busy;
    assign bus.result_valid = r_valid;
    assign bus.tof          = r_tof;
    assign bus.rx_bits      = r_rx_bits;
    assign bus.err_cnt      = r_err_cnt;
    assign bus.hit          = r_hit;
    assign bus.timeout      = r_timeout;
endmodule

// File: tb/tb_echo_decoder.sv
// tb_echo_decoder: directed frame-level stimulus with hand-derived expected results.
module tb_echo_decoder;
    localparam int HP = 9;

    logic clk;
    logic rstn;
    echo_decoder_if bus();

    echo_decoder #(.HALF_PERIOD(HP)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Echo waveform model parameters
    int          g_arr;
    int          g_glitch;
    int          g_k0;
    int          g_s;
    logic [15:0] g_pat;
    logic [15:0] g_inv;

    // Result fields captured at the first result_valid of a frame
    logic [31:0] c_tof;
    logic [15:0] c_rx;
    logic [4:0]  c_err;
    logic        c_hit;
    logic        c_to;
    logic        c_busy1;
    int          rv_cyc;
    int          rv_cnt;

    function automatic logic echo_at(input int n);
        int d;
        int sym;
        logic ref_lvl;
        if (n == g_glitch) return 1'b1;
        if (g_arr < 0 || n < g_arr) return 1'b0;
        d   = n - g_arr;
        sym = g_k0 + d / g_s;
        if (sym > 15) return 1'b0;
        ref_lvl = ((d / HP) % 2) == 0;
        return ref_lvl ^ g_pat[sym] ^ g_pat[g_k0] ^ g_inv[sym];
    endfunction

    task automatic set_cfg(input logic [15:0] pat, input logic [15:0] msk, input logic [15:0] pl,
                           input logic [31:0] blank, input logic [31:0] listen, input logic [4:0] merr);
        bus.pattern    = pat;
        bus.mask       = msk;
        bus.pulse_len  = pl;
        bus.blank_len  = blank;
        bus.listen_len = listen;
        bus.max_err    = merr;
    endtask

    task automatic set_echo(input int arr, input int k0, input int s, input logic [15:0] pat,
                            input logic [15:0] inv, input int glitch);
        g_arr = arr; g_k0 = k0; g_s = s; g_pat = pat; g_inv = inv; g_glitch = glitch;
    endtask

    // Pulse frame_sync at cycle 0, then drive the echo model for ncyc cycles
    task automatic drive_frame(input int ncyc);
        rv_cyc = -1;
        rv_cnt = 0;
        @(negedge clk);
        bus.frame_sync = 1'b1;
        bus.echo       = echo_at(0);
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            if (n == 1) c_busy1 = bus.busy;
            if (bus.result_valid) begin
                if (rv_cnt == 0) begin
                    rv_cyc = n;
                    c_tof  = bus.tof;
                    c_rx   = bus.rx_bits;
                    c_err  = bus.err_cnt;
                    c_hit  = bus.hit;
                    c_to   = bus.timeout;
                end
                rv_cnt++;
            end
            bus.frame_sync = 1'b0;
            bus.echo       = echo_at(n);
        end
    endtask

    task automatic run_idle(input int ncyc);
        rv_cnt = 0;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            if (bus.result_valid) rv_cnt++;
            bus.frame_sync = 1'b0;
            bus.echo       = 1'b0;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.enable = 1'b0; bus.frame_sync = 1'b0; bus.echo = 1'b0;
        set_cfg(16'h0, 16'h0, 16'h0, 32'h0, 32'h0, 5'h0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++;
        if ({bus.result_valid, bus.tof, bus.rx_bits, bus.err_cnt, bus.hit, bus.timeout} !== 56'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rv=%b tof=%0d rx=%h err=%0d hit=%b to=%b expected all 0",
                     bus.result_valid, bus.tof, bus.rx_bits, bus.err_cnt, bus.hit, bus.timeout);
        end
        rstn = 1'b1;
        bus.enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean_echo();
        set_cfg(16'hA5F0, 16'hFFFF, 16'd2, 32'd100, 32'd5000, 5'd0);
        set_echo(1000, 0, 36, 16'hA5F0, 16'h0, -1);
        drive_frame(1580);
        n_checks++;
        if (c_busy1 !== 1'b1) begin n_fail++; $display("FAIL clean_busy: got %b expected 1", c_busy1); end
        n_checks++;
        if (rv_cyc != 1576 || rv_cnt != 1) begin n_fail++; $display("FAIL clean_rv: got cycle %0d count %0d expected 1576 count 1", rv_cyc, rv_cnt); end
        n_checks++;
        if (c_tof !== 32'd1000) begin n_fail++; $display("FAIL clean_tof: got %0d expected 1000", c_tof); end
        n_checks++;
        if (c_rx !== 16'hA5F0) begin n_fail++; $display("FAIL clean_rx: got %h expected a5f0", c_rx); end
        n_checks++;
        if ({c_err, c_hit, c_to} !== {5'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL clean_flags: got err=%0d hit=%b to=%b expected 0 1 0", c_err, c_hit, c_to); end
        run_idle(3);
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL clean_idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_no_echo();
        set_cfg(16'hA5F0, 16'hFFFF, 16'd2, 32'd100, 32'd5000, 5'd0);
        set_echo(-1, 0, 36, 16'hA5F0, 16'h0, -1);
        drive_frame(5004);
        n_checks++;
        if (rv_cyc != 5001) begin n_fail++; $display("FAIL noecho_rv: got cycle %0d expected 5001", rv_cyc); end
        n_checks++;
        if ({c_to, c_hit, c_rx, c_err} !== {1'b1, 1'b0, 16'h0, 5'd0}) begin
            n_fail++; $display("FAIL noecho_fields: got to=%b hit=%b rx=%h err=%0d expected 1 0 0000 0", c_to, c_hit, c_rx, c_err);
        end
    endtask

    task automatic test_blanking();
        set_cfg(16'hA5F0, 16'hFFFF, 16'd2, 32'd100, 32'd5000, 5'd0);
        set_echo(1000, 0, 36, 16'hA5F0, 16'h0, 50);
        drive_frame(1580);
        n_checks++;
        if (c_tof !== 32'd1000) begin n_fail++; $display("FAIL blank_tof: got %0d expected 1000", c_tof); end
        n_checks++;
        if (rv_cyc != 1576) begin n_fail++; $display("FAIL blank_rv: got cycle %0d expected 1576", rv_cyc); end
    endtask

    task automatic test_bit_error();
        set_cfg(16'hA5F0, 16'hFFFF, 16'd2, 32'd100, 32'd5000, 5'd0);
        set_echo(1000, 0, 36, 16'hA5F0, 16'h0008, -1);
        drive_frame(1580);
        n_checks++;
        if (c_rx !== 16'hA5F8) begin n_fail++; $display("FAIL biterr_rx: got %h expected a5f8", c_rx); end
        n_checks++;
        if (c_err !== 5'd1) begin n_fail++; $display("FAIL biterr_err: got %0d expected 1", c_err); end
        n_checks++;
        if (c_hit !== 1'b0) begin n_fail++; $display("FAIL biterr_hit0: got %b expected 0", c_hit); end
        bus.max_err = 5'd1;
        drive_frame(1580);
        n_checks++;
        if ({c_err, c_hit} !== {5'd1, 1'b1}) begin n_fail++; $display("FAIL biterr_hit1: got err=%0d hit=%b expected 1 1", c_err, c_hit); end
    endtask

    task automatic test_partial_mask();
        set_cfg(16'h0A50, 16'h0FF0, 16'd2, 32'd100, 32'd5000, 5'd0);
        set_echo(1000, 4, 36, 16'h0A50, 16'h0, -1);
        drive_frame(1440);
        n_checks++;
        if (rv_cyc != 1432) begin n_fail++; $display("FAIL partial_rv: got cycle %0d expected 1432", rv_cyc); end
        n_checks++;
        if (c_rx !== 16'h0A50) begin n_fail++; $display("FAIL partial_rx: got %h expected 0a50", c_rx); end
        n_checks++;
        if ({c_err, c_hit, c_to} !== {5'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL partial_flags: got err=%0d hit=%b to=%b expected 0 1 0", c_err, c_hit, c_to); end
    endtask

    task automatic test_zero_mask();
        set_cfg(16'hA5F0, 16'h0000, 16'd2, 32'd100, 32'd5000, 5'd0);
        set_echo(-1, 0, 36, 16'hA5F0, 16'h0, -1);
        drive_frame(4);
        n_checks++;
        if (rv_cyc != 1 || rv_cnt != 1) begin n_fail++; $display("FAIL zmask_rv: got cycle %0d count %0d expected 1 count 1", rv_cyc, rv_cnt); end
        n_checks++;
        if ({c_to, c_hit} !== 2'b10) begin n_fail++; $display("FAIL zmask_flags: got to=%b hit=%b expected 1 0", c_to, c_hit); end
    endtask

    task automatic test_pulse_len_zero();
        set_cfg(16'h1234, 16'hFFFF, 16'd0, 32'd100, 32'd5000, 5'd0);
        set_echo(200, 0, 18, 16'h1234, 16'h0, -1);
        drive_frame(495);
        n_checks++;
        if (rv_cyc != 488) begin n_fail++; $display("FAIL pl0_rv: got cycle %0d expected 488", rv_cyc); end
        n_checks++;
        if ({c_tof, c_rx, c_err} !== {32'd200, 16'h1234, 5'd0}) begin
            n_fail++; $display("FAIL pl0_fields: got tof=%0d rx=%h err=%0d expected 200 1234 0", c_tof, c_rx, c_err);
        end
    endtask

    task automatic test_back_to_back();
        set_cfg(16'hA5F0, 16'hFFFF, 16'd2, 32'd100, 32'd5000, 5'd0);
        set_echo(1000, 0, 36, 16'hA5F0, 16'h0, -1);
        drive_frame(1576);
        n_checks++;
        if (rv_cyc != 1576) begin n_fail++; $display("FAIL b2b_first_rv: got cycle %0d expected 1576", rv_cyc); end
        set_echo(700, 0, 36, 16'hA5F0, 16'h0, -1);
        drive_frame(1280);
        n_checks++;
        if (rv_cyc != 1276 || c_tof !== 32'd700) begin n_fail++; $display("FAIL b2b_second: got cycle %0d tof %0d expected 1276 tof 700", rv_cyc, c_tof); end
    endtask

    task automatic test_abort_frame_sync();
        set_cfg(16'hA5F0, 16'hFFFF, 16'd2, 32'd100, 32'd5000, 5'd0);
        set_echo(1000, 0, 36, 16'hA5F0, 16'h0, -1);
        drive_frame(1200);
        n_checks++;
        if (rv_cnt != 0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre: got rv count %0d busy %b expected 0 1", rv_cnt, bus.busy); end
        set_echo(300, 0, 36, 16'hA5F0, 16'h0, -1);
        drive_frame(880);
        n_checks++;
        if (rv_cyc != 876 || rv_cnt != 1) begin n_fail++; $display("FAIL abort_rv: got cycle %0d count %0d expected 876 count 1", rv_cyc, rv_cnt); end
        n_checks++;
        if (c_tof !== 32'd300) begin n_fail++; $display("FAIL abort_tof: got %0d expected 300", c_tof); end
    endtask

    task automatic test_enable_low();
        set_cfg(16'hA5F0, 16'hFFFF, 16'd2, 32'd100, 32'd5000, 5'd0);
        set_echo(1000, 0, 36, 16'hA5F0, 16'h0, -1);
        drive_frame(1100);
        @(negedge clk);
        bus.enable = 1'b0;
        bus.echo   = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL enlow_busy: got %b expected 0", bus.busy); end
        n_checks++;
        if (bus.tof !== 32'd300 || bus.rx_bits !== 16'hA5F0) begin n_fail++; $display("FAIL enlow_hold: got tof=%0d rx=%h expected 300 a5f0", bus.tof, bus.rx_bits); end
        bus.enable = 1'b1;
        run_idle(600);
        n_checks++;
        if (rv_cnt != 0) begin n_fail++; $display("FAIL enlow_norep: got %0d result pulses expected 0", rv_cnt); end
    endtask

    task automatic test_abort_reset();
        set_cfg(16'hA5F0, 16'hFFFF, 16'd2, 32'd100, 32'd5000, 5'd0);
        set_echo(1000, 0, 36, 16'hA5F0, 16'h0, -1);
        drive_frame(1100);
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rstabort_pre: got busy %b expected 1", bus.busy); end
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.result_valid, bus.tof, bus.rx_bits, bus.err_cnt, bus.hit, bus.timeout} !== 57'h0) begin
            n_fail++;
            $display("FAIL rstabort_out: got busy=%b rv=%b tof=%0d rx=%h err=%0d hit=%b to=%b expected all 0",
                     bus.busy, bus.result_valid, bus.tof, bus.rx_bits, bus.err_cnt, bus.hit, bus.timeout);
        end
        rstn = 1'b1;
        run_idle(3);
    endtask

    initial begin
        g_arr = -1; g_glitch = -1; g_k0 = 0; g_s = 36; g_pat = '0; g_inv = '0;
        test_reset();
        test_clean_echo();
        test_no_echo();
        test_blanking();
        test_bit_error();
        test_partial_mask();
        test_zero_mask();
        test_pulse_len_zero();
        test_back_to_back();
        test_abort_frame_sync();
        test_enable_low();
        test_abort_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/echo_decoder.md
# echo_decoder

Receive-side counterpart of the ultrasound pulse generator. Takes the 1-bit comparator output of the receive transducer and restarts on every `frame_sync` from the transmitter. It finds the first echo edge after a blanking interval and reports time-of-flight. It then demodulates the phase-coded pattern symbol by symbol and compares it against the transmitted pattern/mask, producing one result record per frame for the range-processing logic.

## Interface
- `half_period`, 9: carrier half-period in clk cycles. Must equal the transmitter's value.
- `clk`  in  1: clock.
- `rstn`  in  1: reset, synchronous, active-low.
- `enable`  in  1: block active. Low forces IDLE.
- `frame_sync`  in  1: 1-cycle start-of-frame pulse from the transmitter.
- `echo`  in  1: comparator output, asynchronous to clk.
- `pattern`  in  16: transmitted symbol pattern. Latched at `frame_sync`.
- `mask`  in  16: transmitted symbol mask. Latched at `frame_sync`.
- `pulse_len`  in  16: carrier periods per symbol. Latched at `frame_sync`; 0 is treated as 1.
- `blank_len`  in  32: clocks after `frame_sync` during which edges are ignored. Latched.
- `listen_len`  in  32: last tof at which an arrival is accepted. Latched.
- `max_err`  in  5: mismatch threshold for `hit`. Latched.
- `busy`  out  1: state is not IDLE.
- `result_valid`  out  1: 1-cycle pulse; result fields below are valid in that cycle and held until the next pulse.
- `tof`  out  32: clocks from `frame_sync` to arrival.
- `rx_bits`  out  16: decoded absolute symbol values; masked-out positions read 0.
- `err_cnt`  out  5: number of masked-in symbols that differ from `pattern`.
- `hit`  out  1: `!timeout && err_cnt <= max_err`.
- `timeout`  out  1: no arrival detected within the listen window.
- Reset values: all outputs 0.

## Operation
- **States:** IDLE, LISTEN, DECODE, REPORT.
- **Idle exit:** `frame_sync && enable` in any state other than REPORT goes to LISTEN, latches config, and clears `tof_cnt` to 0.
  - A DECODE in progress is aborted silently (no `result_valid`).
  - In REPORT, `frame_sync` is honoured in the next cycle (IDLE).
- **LISTEN:**
  - `tof_cnt` increments each cycle, saturating at 2^32-1.
  - Arrival = internal echo high, previous internal echo low, and `tof_cnt >= blank_len`.
  - On arrival: `tof <= tof_cnt`, then go to DECODE.
  - If `tof_cnt == listen_len` with no arrival: go to REPORT with `timeout=1`, `rx_bits=0`, `err_cnt=0`.
- **Symbol range:** k0 = index of the lowest set bit of `mask`. If `mask==0`, report timeout immediately in the cycle after `frame_sync`.
- **Symbol window:** S = pulse_len*2*half_period clocks (32-bit). Windows run for symbols k = k0..15 back to back; the first window starts in the arrival cycle.
- **Local reference:** square wave, high for `half_period` cycles starting at the arrival cycle, then alternating. Runs continuously across windows.
- **Per-window decision:**
  - `agree` counts cycles where internal echo == ref.
  - Decoded relative bit r[k] = (agree*2 < S) ? 1 : 0; ties decode as 0.
  - Absolute bit b[k] = r[k] ^ pattern[k0].
- **Mismatch count:** `err_cnt` = number of k in k0..15 with mask[k]=1 and b[k] != pattern[k]. Masked-out windows are timed but ignored.
- **Report:** after the last sample of window 15, go to REPORT. REPORT drives `result_valid` for 1 cycle, then returns to IDLE.
- **Enable low:** forces IDLE within 1 cycle, with no report. Result fields keep their last values.
- **Reset mid-operation:** go to IDLE and clear all outputs.

## Timing
- **Timing origin:** the `frame_sync` cycle is t0, where `tof_cnt`=0. An edge seen internally at t0+n gives `tof`=n.
- **Timeout report:** `result_valid` at t0+listen_len+1.
- **Decode report:** `result_valid` at arrival+(16-k0)*S, i.e. one cycle after the last window sample.
- **Frame re-arm:** back-to-back frames require `frame_sync` no earlier than 1 cycle after `result_valid`; an earlier pulse aborts the frame.
- **Counter widths:** `agree` and window counters are 32 bits; tof saturates and does not wrap.

## Configuration
- **`ECHO_SYNC_EN` defined:** `echo` passes through a 2-FF synchronizer before edge detection and correlation. All echo-derived timing, including `tof`, is 2 cycles later than the raw input.
- **`ECHO_SYNC_EN` undefined:** `echo` is used directly. For simulation or an already-synchronous source.

## Test plan
- **Clean echo:** half_period=9, pulse_len=2, pattern=0xA5F0, mask=0xFFFF; echo = transmitted wave delayed to arrive at tof 1000 (no sync) -> `tof`=1000, `rx_bits`=0xA5F0, `err_cnt`=0, `hit`=1, `result_valid` at t0+1000+16*36.
- **No echo:** echo held 0, listen_len=5000 -> `result_valid` at t0+5001 with `timeout`=1, `hit`=0.
- **Blanking:** single echo pulse at tof 50 with blank_len=100, real echo at tof 1000 -> `tof`=1000.
- **Bit error:** as clean echo but symbol 3 phase-inverted, max_err=0 -> `err_cnt`=1, `rx_bits`=0xA5F8, `hit`=0; with max_err=1 -> `hit`=1.
- **Partial mask:** mask=0x0FF0, pattern=0x0A50 -> k0=4, 12 windows, `rx_bits`=0x0A50, report at arrival+12*S.
- **Aborts:** `frame_sync` during DECODE -> no report, new tof measured from the new t0. `rstn` low during DECODE -> all outputs 0, `busy`=0 next cycle.
